// File: rtl/crc9_pkg.sv
// crc9_pkg
// Shared definitions for the G(y) = 1 + y + y^8 + y^9 CRC family.
//   CRC_W    : remainder width (9)
//   CRC_POLY : G(y) without the y^9 term. It is XORed in when the bit
//              shifted out of the top of the register is 1.
//   PAR      : bits processed per clock (3)
//   state_t  : checker frame state {IDLE, RECV, HOLD}
package crc9_pkg;

  localparam int CRC_W = 9;
  localparam logic [CRC_W-1:0] CRC_POLY = 9'h103;
  localparam int PAR = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/crc9_step3.sv
// crc9_step3
// Combinational three-bit advance of the G(y) divider register. The bit-serial
// step is applied PAR times: first d[PAR-1], which is the earliest bit, then
// the remaining bits down to d[0]. The generator shares this module.
// Ports:
//   s      in  [8:0] current remainder
//   d      in  [2:0] three codeword bits, d[2] first
//   s_next out [8:0] remainder after the three bits
module crc9_step3
  import crc9_pkg::*;
(
  input  logic [CRC_W-1:0] s,
  input  logic [PAR-1:0]   d,
  output logic [CRC_W-1:0] s_next
);

  logic [CRC_W-1:0] w_acc;

  always_comb begin
    w_acc = s;
    for (int i = 0; i < PAR; i++) begin
      // Shift in the next bit. Reduce by G when the bit leaving the top is 1.
      w_acc = {w_acc[CRC_W-2:0], d[PAR-1-i]} ^ (w_acc[CRC_W-1] ? CRC_POLY : '0);
    end
  end

  assign s_next = w_acc;

endmodule

// File: rtl/three_parallel_crc_checker.sv
// three_parallel_crc_checker
// Receive-side checker for the three-parallel G(y) CRC code. A codeword
// arrives three bits per beat, MSB first: the message bits, then 9 CRC bits.
// The checker divides the codeword by G(y) and captures the message bits.
// It then presents the syndrome and a pass flag through a valid/ready handshake.
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   data_in[2:0]     beat bits, data_in[2] earliest
//   in_valid/in_sof  beat valid / beat is the first beat of a frame
//   in_ready         a beat can be accepted (low only while holding a result)
//   msg_out          captured message, msg_out[MSG_BITS-1] received first
//   syndrome, crc_ok codeword remainder and (syndrome == 0)
//   out_valid/out_ready  result handshake
//   drop             one-cycle pulse after a beat without in_sof arrives in IDLE
module three_parallel_crc_checker
  import crc9_pkg::*;
#(
  parameter int MSG_BITS = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PAR-1:0]      data_in,
  input  logic                in_valid,
  input  logic                in_sof,
  output logic                in_ready,
  output logic [MSG_BITS-1:0] msg_out,
  output logic [CRC_W-1:0]    syndrome,
  output logic                crc_ok,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                drop
);

  localparam int FRAME_BEATS = (MSG_BITS + CRC_W) / PAR;
  localparam int MSG_BEATS   = MSG_BITS / PAR;
  localparam int CNT_W       = $clog2(FRAME_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);
  localparam logic [CNT_W-1:0] MSG_END   = CNT_W'(MSG_BEATS);

  state_t              r_state;
  logic [CRC_W-1:0]    r_syn;
  logic [CNT_W-1:0]    r_cnt;
  logic [MSG_BITS-1:0] r_msg;
  logic [MSG_BITS-1:0] r_msg_out;
  logic [CRC_W-1:0]    r_syndrome;
  logic                r_crc_ok;
  logic                r_out_valid;
  logic                r_drop;

  logic                w_accept;
  logic [CRC_W-1:0]    w_seed;
  logic [CRC_W-1:0]    w_syn_next;
  logic [MSG_BITS-1:0] w_msg_shift;

  assign w_accept = in_valid & in_ready;
  // An in_sof beat always starts a new division from zero. This also restarts
  // a partial frame.
  assign w_seed   = in_sof ? '0 : r_syn;

  crc9_step3 u_step (
    .s      (w_seed),
    .d      (data_in),
    .s_next (w_syn_next)
  );

  // The message register is a plain shift register. By the last message beat,
  // any bits left from an abandoned frame have been shifted out.
  if (MSG_BITS == PAR) begin : g_msg_min
    assign w_msg_shift = data_in;
  end else begin : g_msg_wide
    assign w_msg_shift = {r_msg[MSG_BITS-PAR-1:0], data_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_syn       <= '0;
      r_cnt       <= '0;
      r_msg       <= '0;
      r_msg_out   <= '0;
      r_syndrome  <= '0;
      r_crc_ok    <= 1'b0;
      r_out_valid <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (in_sof) begin
              r_syn   <= w_syn_next;
              r_cnt   <= CNT_W'(1);
              r_msg   <= w_msg_shift;
              r_state <= RECV;
            end else begin
              r_drop <= 1'b1;
            end
          end
        end
        RECV: begin
          if (w_accept) begin
            if (in_sof) begin
              r_syn <= w_syn_next;
              r_cnt <= CNT_W'(1);
              r_msg <= w_msg_shift;
            end else begin
              r_syn <= w_syn_next;
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt < MSG_END) begin
                r_msg <= w_msg_shift;
              end
              // The last beat is always a CRC beat, so r_msg is already complete.
              if (r_cnt == LAST_BEAT) begin
                r_syndrome  <= w_syn_next;
                r_crc_ok    <= (w_syn_next == '0);
                r_msg_out   <= r_msg;
                r_out_valid <= 1'b1;
                r_syn       <= '0;
                r_cnt       <= '0;
                r_state     <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Decoded only from the state register. There is no path from in_valid or out_ready.
  assign in_ready  = (r_state != HOLD);
  assign msg_out   = r_msg_out;
  assign syndrome  = r_syndrome;
  assign crc_ok    = r_crc_ok;
  assign out_valid = r_out_valid;
  assign drop      = r_drop;

endmodule

// File: doc/three_parallel_crc_checker.md
Name: three_parallel_crc_checker

Overview:
Receive-side CRC checker for the G(y) = 1 + y + y^8 + y^9 code used by the team's three-parallel retimed CRC generator. It accepts a codeword three bits per clock, MSB-first: message bits first, then the 9 CRC bits. It divides the codeword by G(y), captures the message bits, and reports the 9-bit syndrome and a pass/fail flag through a valid/ready result handshake.

Parameters:
MSG_BITS, 9, message length in bits; MSG_BITS must be a multiple of 3 and at least 3, so that (MSG_BITS+9)/3 is a whole number of beats.
FRAME_BEATS, (MSG_BITS+9)/3 (derived localparam, 6 at default), beats per codeword.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
data_in  input  3  codeword bits for this beat; data_in[2] is the earliest bit
in_valid  input  1  data_in is valid this cycle
in_sof  input  1  qualifies data_in as beat 0 of a frame
in_ready  output  1  checker can accept a beat
msg_out  output  MSG_BITS  captured message; msg_out[MSG_BITS-1] is the first bit received
syndrome  output  9  remainder of the codeword mod G(y)
crc_ok  output  1  syndrome == 0
out_valid  output  1  result fields are valid
out_ready  input  1  downstream accepts the result
drop  output  1  one-cycle pulse when a beat is discarded

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, internal syndrome register 0, beat counter 0. Outputs: out_valid 0, crc_ok 0, syndrome 0, msg_out 0, drop 0, in_ready 1.
- Reset mid-frame or while holding a result discards everything. No out_valid is produced for that frame.
- Accept: a beat is accepted when in_valid & in_ready.
- Serial step for one bit b: fb = s[8]; s_next = {s[7:0], b} ^ (fb ? 9'h103 : 9'h000).
- Per accepted beat, the step is applied three times, in order data_in[2], data_in[1], data_in[0]. This is purely combinational within the cycle.
- Message capture: beats 0 .. MSG_BITS/3-1 are shifted into the message register, 3 bits at a time, MSB-first.
- in_ready = (state != HOLD). It is decoded from the state register, with no combinational path from in_valid or out_ready.
- IDLE:
  - Accepted beat with in_sof=1: syndrome = step3(0, data_in), counter = 1, go to RECV.
  - Accepted beat with in_sof=0: beat discarded, drop pulses the next cycle, stay in IDLE.
- RECV:
  - Accepted beat with in_sof=1: the frame restarts. The partial frame is silently discarded and this beat is treated as beat 0.
  - Accepted beat with in_sof=0: syndrome and counter update.
  - When the counter equals FRAME_BEATS-1 on an accepted beat, the final syndrome, crc_ok and message are latched into the output registers, and the state goes to HOLD.
  - No in_valid: the state holds indefinitely. Gaps between beats are legal.
- HOLD:
  - out_valid = 1 and the output fields are stable.
  - out_ready = 1 causes out_valid = 0 and a return to IDLE on the next cycle.
  - Beats are not accepted in HOLD (in_ready = 0).
- Latency: out_valid rises on the cycle after the last beat is accepted.
- Throughput: minimum FRAME_BEATS+1 cycles per frame when out_ready is held at 1.
- The output fields keep their last values after the handshake until the next result is latched.

Decomposition:
- Package crc9_pkg: CRC_W = 9, CRC_POLY = 9'h103 (G without the y^9 term), PAR = 3, and the state enum {IDLE, RECV, HOLD}.
- Sub-module crc9_step3: combinational; inputs s[8:0] and d[2:0], output the next s after the three serial steps. It is natural to share this module with the generator.

Test Plan:
1. Good frame: after reset, send in_sof + 101, then 011, 010, 010, 110, 110 on consecutive cycles (message 101011010, CRC 010110110), with out_ready=1. Required: out_valid high one cycle after the 6th beat, syndrome=000000000, crc_ok=1, msg_out=101011010.
2. Single-bit error: same frame with the last beat 111. Required: syndrome=000000001, crc_ok=0, msg_out=101011010.
3. Backpressure: out_ready=0 for 5 cycles after the result. Required: out_valid and the fields stay stable, and in_ready=0. After one cycle with out_ready=1, in_ready=1 on the next cycle; a new frame is then accepted and checked correctly.
4. Stray beat and restart:
   - A beat without in_sof in IDLE: drop pulses, and no result follows.
   - 3 beats of a frame, then a new in_sof beat followed by the full good frame: the single result is syndrome=0, crc_ok=1.
5. Gaps and reset: insert in_valid=0 gaps between beats of the good frame; the result is identical to scenario 1. Assert reset after beat 4 of a frame: no out_valid follows, in_ready=1, and the next good frame passes.
